// File: rtl/register_bus_pkg.sv
// Shared definitions for the register bus arbiter: FSM encoding, default
// widths and the data pattern returned when an access times out.
package register_bus_pkg;

  localparam int DEFAULT_INDEX_WIDTH    = 7;
  localparam int DEFAULT_DATA_WIDTH     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Widest data bus supported; TIMEOUT_RDATA is sliced down to DATA_WIDTH.
  localparam int MAX_DATA_WIDTH = 64;
  localparam logic [MAX_DATA_WIDTH-1:0] TIMEOUT_RDATA = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive cycles with count_en high and flags the cycle in which
// the count reaches TIMEOUT_CYCLES. Cleared whenever count_en is low.
module bus_timeout_counter
  import register_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // Count enabled cycles; restart from zero as soon as the enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + 1'b1;
    end else begin
      count_q <= '0;
    end
  end

  // count_q is 0 in the first enabled cycle, so the last allowed cycle is N-1.
  assign expired = count_en && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/register_bus_arbiter.sv
// Two-requester arbiter in front of a single register peripheral.
// Optional build macro REG_BUS_TIMEOUT_EN: aborts a BUSY access after
// TIMEOUT_CYCLES cycles without register_ready, returning all-ones with err.
//
// Handshakes:
//   requester side  - reqN is raised together with weN/indexN/wdataN and held
//                     until ackN; the fields are latched at grant, so later
//                     changes (including dropping reqN) do not affect the
//                     access in flight. ackN is a one-cycle pulse; rdata and
//                     err are valid while it is high. reqN must drop in the
//                     ack cycle or it is treated as a new request.
//   peripheral side - register_read/register_write are held with a stable
//                     register_index/register_write_value until the cycle in
//                     which register_ready is sampled high.
module register_bus_arbiter
  import register_bus_pkg::*;
#(
  parameter int INDEX_WIDTH    = DEFAULT_INDEX_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [INDEX_WIDTH-1:0] index0,
  input  logic [INDEX_WIDTH-1:0] index1,
  input  logic [DATA_WIDTH-1:0]  wdata0,
  input  logic [DATA_WIDTH-1:0]  wdata1,
  output logic                   ack0,
  output logic                   ack1,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   err,
  output logic [INDEX_WIDTH-1:0] register_index,
  output logic                   register_read,
  output logic                   register_write,
  output logic [DATA_WIDTH-1:0]  register_write_value,
  input  logic [DATA_WIDTH-1:0]  register_read_value,
  input  logic                   register_ready,
  output state_t                 state_dbg
);

  state_t                 state, state_nxt;
  logic                   gnt_q;      // port owning the current access
  logic                   prio_q;     // port that wins a tie
  logic                   grant_sel;  // port chosen this cycle in IDLE
  logic                   we_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   timeout_hit;

`ifdef REG_BUS_TIMEOUT_EN
  logic err_q;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .count_en (state == ST_BUSY),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // On a tie the priority port wins; otherwise whichever port is requesting.
  always_comb begin
    grant_sel = req1;
    if (req0 && req1) grant_sel = prio_q;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> BUSY on any request, BUSY -> RESP on ready or
  // timeout, RESP always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req0 || req1) state_nxt = ST_BUSY;
      ST_BUSY: if (register_ready || timeout_hit) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, request latching and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      index_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef REG_BUS_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE && (req0 || req1)) begin
        gnt_q   <= grant_sel;
        prio_q  <= ~grant_sel;
        we_q    <= grant_sel ? we1 : we0;
        index_q <= grant_sel ? index1 : index0;
        wdata_q <= grant_sel ? wdata1 : wdata0;
      end
      if (state == ST_BUSY) begin
        // A ready arriving in the last allowed cycle still completes normally.
        if (register_ready) begin
          rdata_q <= we_q ? '0 : register_read_value;
`ifdef REG_BUS_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end else if (timeout_hit) begin
          rdata_q <= TIMEOUT_RDATA[DATA_WIDTH-1:0];
`ifdef REG_BUS_TIMEOUT_EN
          err_q   <= 1'b1;
`endif
        end
      end
    end
  end

  // Output decode: strobes only in BUSY, ack/err only in RESP.
  always_comb begin
    register_read  = 1'b0;
    register_write = 1'b0;
    ack0           = 1'b0;
    ack1           = 1'b0;
    err            = 1'b0;
    case (state)
      ST_BUSY: begin
        register_read  = ~we_q;
        register_write = we_q;
      end
      ST_RESP: begin
        ack0 = ~gnt_q;
        ack1 = gnt_q;
`ifdef REG_BUS_TIMEOUT_EN
        err  = err_q;
`endif
      end
      default: ;
    endcase
  end

  assign register_index       = index_q;
  assign register_write_value = wdata_q;
  assign rdata                = rdata_q;
  assign state_dbg            = state;

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Bench for register_bus_arbiter: directed scenarios with literal
// expectations, then two randomized requesters against a random-latency
// peripheral, all shadowed by a transaction-level reference model.
module tb_register_bus_arbiter;
  import register_bus_pkg::*;

  localparam int IW = 7;
  localparam int DW = 16;
  localparam int TO = 16;
  localparam logic [DW-1:0] ALL_ONES = '1;

  logic          clk;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [IW-1:0] index0, index1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err;
  logic [DW-1:0] rdata;
  logic [IW-1:0] register_index;
  logic          register_read, register_write;
  logic [DW-1:0] register_write_value;
  logic [DW-1:0] register_read_value;
  logic          register_ready;
  state_t        state_dbg;

  int total = 0;
  int bad   = 0;

  register_bus_arbiter #(
    .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .index0(index0), .index1(index1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value), .register_ready(register_ready),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- peripheral model ----------------
  // ready_mode 0: ready after wait_n low cycles; 1: random; 2: never.
  int            ready_mode = 0;
  int            wait_n     = 0;
  bit            use_fixed  = 0;
  logic [DW-1:0] fixed_rv   = '0;
  int            pwait      = 0;

  always @(negedge clk) begin
    register_read_value = use_fixed ? fixed_rv : DW'($urandom);
    if (register_read || register_write) begin
      case (ready_mode)
        0:       register_ready = (pwait >= wait_n);
        1:       register_ready = ($urandom_range(0, 3) == 0);
        default: register_ready = 1'b0;
      endcase
      pwait++;
    end else begin
      register_ready = 1'b0;
      pwait = 0;
    end
  end

  // ---------------- reference model ----------------
  // One access at a time: it is granted, waits on the peripheral, then
  // responds for a single cycle. A tie goes to the port not served last.
  logic          mdl_busy, mdl_resp, mdl_we, mdl_err;
  int            mdl_port, mdl_last, mdl_wait;
  logic [IW-1:0] mdl_index;
  logic [DW-1:0] mdl_wdata, mdl_rdata;
  logic [DW-1:0] exp_q[$];

  function automatic int pick_port(input logic r0, input logic r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_busy  <= 1'b0;
      mdl_resp  <= 1'b0;
      mdl_we    <= 1'b0;
      mdl_err   <= 1'b0;
      mdl_port  <= 0;
      mdl_last  <= -1;
      mdl_wait  <= 0;
      mdl_index <= '0;
      mdl_wdata <= '0;
      mdl_rdata <= '0;
      exp_q.delete();
    end else if (mdl_resp) begin
      mdl_resp <= 1'b0;
    end else if (mdl_busy) begin
      mdl_wait <= mdl_wait + 1;
      if (register_ready) begin
        mdl_busy  <= 1'b0;
        mdl_resp  <= 1'b1;
        mdl_err   <= 1'b0;
        mdl_rdata <= mdl_we ? '0 : register_read_value;
        exp_q.push_back(mdl_we ? '0 : register_read_value);
      end
`ifdef REG_BUS_TIMEOUT_EN
      else if (mdl_wait + 1 == TO) begin
        mdl_busy  <= 1'b0;
        mdl_resp  <= 1'b1;
        mdl_err   <= 1'b1;
        mdl_rdata <= ALL_ONES;
        exp_q.push_back(ALL_ONES);
      end
`endif
    end else if (req0 || req1) begin
      mdl_busy  <= 1'b1;
      mdl_wait  <= 0;
      mdl_port  <= pick_port(req0, req1, mdl_last);
      mdl_last  <= pick_port(req0, req1, mdl_last);
      mdl_we    <= (pick_port(req0, req1, mdl_last) == 1) ? we1 : we0;
      mdl_index <= (pick_port(req0, req1, mdl_last) == 1) ? index1 : index0;
      mdl_wdata <= (pick_port(req0, req1, mdl_last) == 1) ? wdata1 : wdata0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("register_read", register_read, mdl_busy && !mdl_we);
      check("register_write", register_write, mdl_busy && mdl_we);
      if (mdl_busy) begin
        check("register_index", register_index, mdl_index);
        check("register_write_value", register_write_value, mdl_wdata);
      end
      check("ack0", ack0, mdl_resp && mdl_port == 0);
      check("ack1", ack1, mdl_resp && mdl_port == 1);
      check("err", err, mdl_resp && mdl_err);
      check("rdata", rdata, mdl_rdata);
      if (ack0 || ack1) begin
        check("ack_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("ack_rdata_sb", rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic v);
    if (p == 0) req0 = v;
    else        req1 = v;
  endtask

  task automatic set_fields(input int p);
    if (p == 0) begin
      we0 = 1'($urandom_range(0, 1)); index0 = IW'($urandom); wdata0 = DW'($urandom);
    end else begin
      we1 = 1'($urandom_range(0, 1)); index1 = IW'($urandom); wdata1 = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for an ack, drops that port's req in the ack cycle.
  task automatic wait_ack(output int port, output logic e, output logic [DW-1:0] rd);
    port = -1;
    e    = 1'b0;
    rd   = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        port = ack1 ? 1 : 0;
        e    = err;
        rd   = rdata;
        set_req(port, 1'b0);
        break;
      end
    end
  endtask

  // Randomized requester: random gaps, fields scrambled while pending,
  // occasional early req drop once the model shows the port is being served.
  task automatic drive_port(input int p, input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      set_fields(p);
      set_req(p, 1'b1);
      got = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if ((p == 0 && ack0) || (p == 1 && ack1)) begin
          set_req(p, 1'b0);
          got = 1;
          break;
        end
        if ($urandom_range(0, 3) == 0) set_fields(p);
        if (mdl_busy && mdl_port == p && $urandom_range(0, 7) == 0) set_req(p, 1'b0);
      end
      check((p == 0) ? "rand_ack_port0" : "rand_ack_port1", got, 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int            port;
    logic          e;
    logic [DW-1:0] rd;
    int            wcount;
    int            bcount;
    bit            stable_ok;
    bit            ack_seen;

    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    index0 = '0; index1 = '0; wdata0 = '0; wdata1 = '0;
    register_ready = 1'b0;
    register_read_value = '0;
    repeat (3) @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata", rdata, 0);
    check("rst_read", register_read, 0);
    check("rst_write", register_write, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    // Single read of index 5 returning 1234.
    use_fixed = 1; fixed_rv = 16'h1234; ready_mode = 0; wait_n = 0;
    @(negedge clk);
    req0 = 1; we0 = 0; index0 = 7'h05; wdata0 = DW'($urandom);
    @(posedge clk); #1;
    check("rd_strobe_c1", register_read, 1);
    check("rd_index_c1", register_index, 7'h05);
    @(posedge clk); #1;
    check("rd_ack0_c2", ack0, 1);
    check("rd_ack1_c2", ack1, 0);
    check("rd_rdata_c2", rdata, 16'h1234);
    check("rd_strobe_c2", register_read, 0);
    req0 = 0;
    @(posedge clk); #1;
    check("rd_ack0_c3", ack0, 0);
    check("rd_rdata_hold", rdata, 16'h1234);
    use_fixed = 0;

    // Contention from reset: 0 then 1, twice.
    do_reset();
    @(negedge clk);
    set_fields(0); set_fields(1);
    req0 = 1; req1 = 1;
    wait_ack(port, e, rd); check("cont_first", port, 0);
    wait_ack(port, e, rd); check("cont_second", port, 1);
    @(negedge clk);
    req0 = 1; req1 = 1;
    wait_ack(port, e, rd); check("cont_third", port, 0);
    wait_ack(port, e, rd); check("cont_fourth", port, 1);

    // Write BEEF to 7F with five wait states; inputs scrambled after grant.
    wait_n = 5;
    @(negedge clk);
    req1 = 1; we1 = 1; index1 = 7'h7F; wdata1 = 16'hBEEF;
    wcount = 0; stable_ok = 1; port = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (register_write) begin
        wcount++;
        if (register_write_value !== 16'hBEEF || register_index !== 7'h7F) stable_ok = 0;
        we1 = 1'($urandom_range(0, 1)); index1 = IW'($urandom); wdata1 = DW'($urandom);
      end
      if (ack1) begin
        port = 1;
        check("ws_rdata", rdata, 0);
        req1 = 0;
        break;
      end
    end
    check("ws_write_cycles", wcount, 6);
    check("ws_value_stable", stable_ok, 1);
    check("ws_acked_port", port, 1);
    wait_n = 0;

`ifdef REG_BUS_TIMEOUT_EN
    // Peripheral never answers: abort after TO busy cycles.
    ready_mode = 2;
    @(negedge clk);
    req0 = 1; we0 = 0; index0 = IW'($urandom);
    bcount = 0; port = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (register_read) bcount++;
      if (ack0) begin
        port = 0;
        check("to_err", err, 1);
        check("to_rdata", rdata, 16'hFFFF);
        req0 = 0;
        break;
      end
    end
    check("to_busy_cycles", bcount, TO);
    check("to_acked_port", port, 0);
    ready_mode = 0; wait_n = 1;
    @(negedge clk);
    req0 = 1; we0 = 0; index0 = IW'($urandom);
    wait_ack(port, e, rd);
    check("to_next_port", port, 0);
    check("to_next_err", e, 0);
    wait_n = 0;
`else
    bcount = 0;
`endif

    // Reset in the second BUSY cycle of a write by port 0.
    ready_mode = 2;
    @(negedge clk);
    req0 = 1; we0 = 1; index0 = IW'($urandom); wdata0 = DW'($urandom);
    @(posedge clk);
    @(posedge clk); #2;
    check("mid_busy_write", register_write, 1);
    reset = 1'b1;
    #1;
    check("rst_async_write", register_write, 0);
    check("rst_async_read", register_read, 0);
    req0 = 0;
    ack_seen = 0;
    repeat (3) begin
      @(negedge clk);
      ack_seen |= (ack0 || ack1);
    end
    reset = 1'b0;
    ready_mode = 0; wait_n = 0;
    repeat (3) begin
      @(negedge clk);
      ack_seen |= (ack0 || ack1);
    end
    check("rst_no_ack", ack_seen, 0);
    req0 = 1; req1 = 1;
    set_fields(0); set_fields(1);
    wait_ack(port, e, rd); check("rst_prio_first", port, 0);
    wait_ack(port, e, rd); check("rst_prio_second", port, 1);

    // Randomized traffic from both requesters.
    ready_mode = 1;
    fork
      drive_port(0, 40);
      drive_port(1, 40);
    join
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bus_arbiter.md
REGISTER_BUS_ARBITER -- requirements
Module: register_bus_arbiter

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 7: hardware register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: register data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of BUSY cycles before abort (timeout build only).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 each: requester access request, held high until ack.
REQ-007 SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read.
REQ-008 SHALL have ports index0/index1, input, INDEX_WIDTH each: target register index.
REQ-009 SHALL have ports wdata0/wdata1, input, DATA_WIDTH each: write data.
REQ-010 SHALL have ports ack0/ack1, output, 1 each: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, DATA_WIDTH: read data, valid while either ack is high.
REQ-012 SHALL have port err, output, 1: one-cycle pulse, coincident with ack, when an access timed out.
REQ-013 SHALL have ports register_index (INDEX_WIDTH), register_read (1), register_write (1) and register_write_value (DATA_WIDTH), all outputs: peripheral-side strobes and data.
REQ-014 SHALL have port register_read_value, input, DATA_WIDTH: peripheral read data.
REQ-015 SHALL have port register_ready, input, 1: peripheral completion, sampled in BUSY.

Function
REQ-016 SHALL implement states IDLE, BUSY and RESP.
REQ-017 In IDLE with any req high, SHALL grant one port, latch its we/index/wdata, and enter BUSY on the next edge.
REQ-018 SHALL grant by round-robin: when both req are high, the port not granted last wins; after reset, port 0 has priority.
REQ-019 In BUSY, SHALL drive register_read = !latched_we and register_write = latched_we, together with the latched index and data; in IDLE and RESP, both strobes SHALL be 0.
REQ-020 In BUSY with register_ready = 1 at an edge, SHALL capture register_read_value (reads only) into rdata and enter RESP.
REQ-021 In RESP, SHALL assert ack for the granted port only, for exactly one cycle, then return to IDLE.
REQ-022 SHALL hold rdata from capture until the next capture; after a write, rdata SHALL be 0 during RESP.
REQ-023 Minimum access time SHALL be: req sampled at edge 0, BUSY in cycle 1, RESP in cycle 2, next grant possible at edge 3.
REQ-024 A req dropped while the port is in BUSY SHALL NOT abort the access; the ack SHALL still issue.
REQ-025 A req high in RESP SHALL NOT be granted until IDLE; the requester SHALL drop req in its ack cycle.
REQ-026 Changes on the requester inputs after the grant SHALL NOT affect the access in flight.

Reset
REQ-027 Reset SHALL immediately force IDLE, both strobes, ack0, ack1 and err to 0, rdata and all latched fields to 0, the timeout counter to 0, and priority to port 0.
REQ-028 Reset asserted in BUSY SHALL deassert the strobes asynchronously, with no ack issued afterward.

Configuration
REQ-029 With REG_BUS_TIMEOUT_EN defined, SHALL count BUSY cycles and, on reaching TIMEOUT_CYCLES without register_ready, enter RESP with rdata = all ones, err = 1 and the normal ack.
REQ-030 Without REG_BUS_TIMEOUT_EN, BUSY SHALL wait indefinitely, err SHALL be tied 0, and no counter SHALL be instantiated.

Structure
REQ-031 Package register_bus_pkg SHALL hold the state encoding, default widths, and the TIMEOUT_RDATA (all-ones) constant.
REQ-032 The timeout counter SHALL be sub-module bus_timeout_counter, instantiated only under REG_BUS_TIMEOUT_EN.

Verification
REQ-033 Single read: req0 with index 7'h05, peripheral ready=1 returning 16'h1234 -> register_read high for 1 cycle, ack0 at cycle 2, rdata = 16'h1234, ack1 = 0.
REQ-034 Contention: req0 and req1 both high from reset -> port 0 served first, port 1 next; repeat with both high -> port 0 then port 1 again, alternating.
REQ-035 Wait states: write 16'hBEEF to 7'h7F, ready held low 5 cycles -> register_write high 6 cycles, with value stable throughout, then ack.
REQ-036 Timeout (REG_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): ready never asserted -> after 16 BUSY cycles, ack + err, rdata = 16'hFFFF; next request served normally.
REQ-037 Reset mid-access: reset asserted in cycle 2 of BUSY -> strobes 0 immediately, no ack, and after release priority is port 0.
